// File: rtl/mmio_ram.sv
// mmio_ram: single-port synchronous RAM with a 16-word memory-mapped I/O window.
// The window sits at the top of the address space and holds the output registers,
// with register 0 as the prescale value. It also holds the synchronised switch
// ports and a button block that captures rising edges and clears them on read.
module mmio_ram #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16384,
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 1,
    parameter logic [DATA_W-1:0] OUT_RST = '0
) (
    input  logic                      mem_clk,
    input  logic                      mem_reset,
    input  logic [ADDR_W-1:0]         address,
    input  logic [DATA_W-1:0]         mem_di,
    input  logic                      read,
    input  logic                      write,
    output logic [DATA_W-1:0]         mem_do,
    output logic                      mem_rvalid,
    input  logic [NUM_IN*DATA_W-1:0]  sw_in,
    input  logic [DATA_W-1:0]         btn,
    output logic [NUM_OUT*DATA_W-1:0] out_regs
);

    localparam int MMIO_BASE = 2**ADDR_W - 16;
    localparam int RAM_AW    = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] DEPTH_A     = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] MMIO_BASE_A = ADDR_W'(MMIO_BASE);
    localparam logic [3:0]        EDGE_OFF    = 4'(NUM_OUT + NUM_IN);
    localparam logic [3:0]        LEVEL_OFF   = 4'(NUM_OUT + NUM_IN + 1);

    logic [DATA_W-1:0]        ram [DEPTH];
    logic [DATA_W-1:0]        ram_q;
    logic [DATA_W-1:0]        mmio_q;
    logic                     rd_from_ram;
    logic [DATA_W-1:0]        mmio_rdata;
    logic [DATA_W-1:0]        out_q [NUM_OUT];
    logic [NUM_IN*DATA_W-1:0] sw_meta;
    logic [NUM_IN*DATA_W-1:0] sw_sync;
    logic [DATA_W-1:0]        btn_meta;
    logic [DATA_W-1:0]        btn_sync;
    logic [DATA_W-1:0]        btn_prev;
    logic [DATA_W-1:0]        btn_edge;
    logic                     is_ram;
    logic                     is_mmio;
    logic [3:0]               offset;
    logic                     edge_clear;

    // The MMIO base is 16-aligned, so the low four address bits are the window offset.
    assign is_ram     = address < DEPTH_A;
    assign is_mmio    = address >= MMIO_BASE_A;
    assign offset     = address[3:0];
    assign edge_clear = read && is_mmio && (offset == EDGE_OFF);

    // RAM array with a read-first output register. It is kept free of reset so it maps onto block RAM.
    always_ff @(posedge mem_clk) begin
        if (!mem_reset && is_ram) begin
            if (write)
                ram[address[RAM_AW-1:0]] <= mem_di;
            if (read)
                ram_q <= ram[address[RAM_AW-1:0]];
        end
    end

    // Read mux for the MMIO window. Unmapped offsets and addresses outside the window read as zero.
    always_comb begin
        mmio_rdata = '0;
        if (is_mmio) begin
            for (int k = 0; k < NUM_OUT; k++)
                if (offset == 4'(k))
                    mmio_rdata = out_q[k];
            for (int k = 0; k < NUM_IN; k++)
                if (offset == 4'(NUM_OUT + k))
                    mmio_rdata = sw_sync[k*DATA_W +: DATA_W];
            if (offset == EDGE_OFF)
                mmio_rdata = btn_edge;
            if (offset == LEVEL_OFF)
                mmio_rdata = btn_sync;
        end
    end

    // Register the read result, its source and the valid strobe. The data holds until the next read.
    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            mmio_q      <= '0;
            rd_from_ram <= 1'b0;
            mem_rvalid  <= 1'b0;
        end else begin
            mem_rvalid <= read;
            if (read) begin
                rd_from_ram <= is_ram;
                mmio_q      <= is_ram ? '0 : mmio_rdata;
            end
        end
    end

    assign mem_do = rd_from_ram ? ram_q : mmio_q;

    // Output registers. Only offsets below NUM_OUT are writable.
    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            for (int k = 0; k < NUM_OUT; k++)
                out_q[k] <= OUT_RST;
        end else if (write && is_mmio) begin
            for (int k = 0; k < NUM_OUT; k++)
                if (offset == 4'(k))
                    out_q[k] <= mem_di;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_OUT; g++) begin : g_out
            assign out_regs[g*DATA_W +: DATA_W] = out_q[g];
        end
    endgenerate

    // Two-flop synchronisers for switches and buttons, plus a delayed button copy for edge detection.
    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
            btn_prev <= '0;
        end else begin
            sw_meta  <= sw_in;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    // Sticky rising-edge capture. A read of the register clears it, but a rise in the same cycle still sets its bit.
    always_ff @(posedge mem_clk) begin
        if (mem_reset)
            btn_edge <= '0;
        else
            btn_edge <= (edge_clear ? '0 : btn_edge) | (btn_sync & ~btn_prev);
    end

endmodule
